// File: rtl/fp16_addsub_unit.sv
// fp16_addsub_unit
// Single-entry, multi-cycle IEEE 754 binary16 adder/subtractor.
// Responder side of the FPU operation handshake.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   operands_i   [0]=A, [1]=B, FP16
//   op_mod_i     0: A+B, 1: A-B
//   rnd_mode_i   3'b001 RTZ, every other code RNE
//   tag_i        request tag, returned unchanged on tag_o
//   in_valid_i   request valid
//   in_ready_o   unit can accept a request (IDLE only)
//   result_o     FP16 result
//   status_o     {NV,DZ,OF,UF,NX}
//   tag_o        tag of the returned result
//   out_valid_o  response valid (DONE)
//   out_ready_i  initiator accepts the response
//   flush_i      synchronous kill of any in-flight operation
//   busy_o       operation in flight or response pending
//
// Pipeline of states: IDLE -> ALIGN -> NORM -> DONE -> IDLE.
// Acceptance edge T, out_valid_o rises after edge T+2.

module fp16_addsub_unit #(
  parameter int unsigned TagWidth = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [1:0][15:0]    operands_i,
  input  logic                op_mod_i,
  input  logic [2:0]          rnd_mode_i,
  input  logic [TagWidth-1:0] tag_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  output logic [15:0]         result_o,
  output logic [4:0]          status_o,
  output logic [TagWidth-1:0] tag_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  input  logic                flush_i,
  output logic                busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    NORM  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_reg, state_next;
  logic   accept;

  // ------------------------------------------------------------------
  // FSM
  // ------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = 1'b1;
    case (state_reg)
      IDLE: begin
        in_ready_o = 1'b1;
        busy_o     = 1'b0;
        if (in_valid_i) state_next = ALIGN;
      end
      ALIGN: state_next = NORM;
      NORM:  state_next = DONE;
      DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // flush overrides every transition, including acceptance in IDLE
    if (flush_i) state_next = IDLE;
  end

  assign accept = in_ready_o && in_valid_i && !flush_i;

  // ------------------------------------------------------------------
  // Request capture
  // ------------------------------------------------------------------
  logic [15:0]         opnd_reg [2];
  logic                op_sub_reg;
  logic                rtz_reg;
  logic [TagWidth-1:0] tag_req_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      opnd_reg[0] <= '0;
      opnd_reg[1] <= '0;
      op_sub_reg  <= 1'b0;
      rtz_reg     <= 1'b0;
      tag_req_reg <= '0;
    end else if (accept) begin
      opnd_reg[0] <= operands_i[0];
      opnd_reg[1] <= operands_i[1];
      op_sub_reg  <= op_mod_i;
      rtz_reg     <= (rnd_mode_i == 3'b001);
      tag_req_reg <= tag_i;
    end
  end

  // ------------------------------------------------------------------
  // ALIGN: unpack and classify both operands
  // ------------------------------------------------------------------
  logic        sgn     [2];  // effective sign (B already flipped for subtract)
  logic [4:0]  exp_eff [2];  // subnormals use exponent 1
  logic [10:0] sig     [2];  // significand with hidden bit
  logic        is_nan  [2];
  logic        is_snan [2];
  logic        is_inf  [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
    logic [4:0] exp_f;
    logic [9:0] frac;
    assign exp_f        = opnd_reg[gi][14:10];
    assign frac         = opnd_reg[gi][9:0];
    assign sgn[gi]      = opnd_reg[gi][15] ^ (op_sub_reg & (gi == 1));
    assign exp_eff[gi]  = (exp_f == 5'd0) ? 5'd1 : exp_f;
    assign sig[gi]      = {exp_f != 5'd0, frac};
    assign is_nan[gi]   = (exp_f == 5'h1F) && (frac != 10'd0);
    assign is_snan[gi]  = is_nan[gi] && !frac[9];
    assign is_inf[gi]   = (exp_f == 5'h1F) && (frac == 10'd0);
  end

  // Special-value resolution
  logic        spec_hit;
  logic [15:0] spec_res;
  logic        spec_nv;

  always_comb begin
    spec_hit = 1'b1;
    spec_res = 16'h7E00;
    spec_nv  = 1'b0;
    if (is_nan[0] || is_nan[1]) begin
      spec_nv = is_snan[0] || is_snan[1];
    end else if (is_inf[0] && is_inf[1]) begin
      if (sgn[0] != sgn[1]) spec_nv = 1'b1;
      else                  spec_res = {sgn[0], 15'h7C00};
    end else if (is_inf[0]) begin
      spec_res = {sgn[0], 15'h7C00};
    end else if (is_inf[1]) begin
      spec_res = {sgn[1], 15'h7C00};
    end else begin
      spec_hit = 1'b0;
    end
  end

  // Swap so |X| >= |Y|, then shift Y right into guard/round/sticky
  logic        swap;
  logic        x_sign;
  logic [4:0]  x_exp, y_exp, exp_diff;
  logic [10:0] x_sig, y_sig;
  logic [3:0]  shift_amt;
  logic [27:0] y_wide;
  logic [13:0] y_aligned;

  always_comb begin
    swap      = opnd_reg[1][14:0] > opnd_reg[0][14:0];
    x_sign    = swap ? sgn[1]     : sgn[0];
    x_exp     = swap ? exp_eff[1] : exp_eff[0];
    y_exp     = swap ? exp_eff[0] : exp_eff[1];
    x_sig     = swap ? sig[1]     : sig[0];
    y_sig     = swap ? sig[0]     : sig[1];
    exp_diff  = x_exp - y_exp;
    shift_amt = (exp_diff > 5'd14) ? 4'd14 : exp_diff[3:0];
    y_wide    = {y_sig, 3'b000, 14'd0} >> shift_amt;
    // everything shifted past the round bit collapses into the sticky bit
    y_aligned = {y_wide[27:15], y_wide[14] | (|y_wide[13:0])};
  end

  logic        spec_hit_reg;
  logic [15:0] spec_res_reg;
  logic        spec_nv_reg;
  logic        x_sign_reg;
  logic        eff_sub_reg;
  logic [4:0]  x_exp_reg;
  logic [13:0] x_man_reg;
  logic [13:0] y_man_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      spec_hit_reg <= 1'b0;
      spec_res_reg <= '0;
      spec_nv_reg  <= 1'b0;
      x_sign_reg   <= 1'b0;
      eff_sub_reg  <= 1'b0;
      x_exp_reg    <= '0;
      x_man_reg    <= '0;
      y_man_reg    <= '0;
    end else if (state_reg == ALIGN) begin
      spec_hit_reg <= spec_hit;
      spec_res_reg <= spec_res;
      spec_nv_reg  <= spec_nv;
      x_sign_reg   <= x_sign;
      eff_sub_reg  <= sgn[0] ^ sgn[1];
      x_exp_reg    <= x_exp;
      x_man_reg    <= {x_sig, 3'b000};
      y_man_reg    <= y_aligned;
    end
  end

  // ------------------------------------------------------------------
  // NORM: add, normalize, round, pack
  // ------------------------------------------------------------------
  logic [14:0] sum;
  logic [3:0]  lz;
  logic [4:0]  max_sh;
  logic [3:0]  sh;
  logic [13:0] norm_man;
  logic [5:0]  norm_exp;
  logic        inexact;
  logic        rnd_up;
  logic [11:0] rounded;
  logic [5:0]  fin_exp;
  logic [9:0]  fin_frac;
  logic        ovf;
  logic        uf;
  logic [15:0] res_next;
  logic [4:0]  sts_next;

  always_comb begin
    sum = eff_sub_reg ? ({1'b0, x_man_reg} - {1'b0, y_man_reg})
                      : ({1'b0, x_man_reg} + {1'b0, y_man_reg});

    lz = 4'd14;
    for (int i = 0; i < 14; i++) begin
      if (sum[i]) lz = 4'(13 - i);
    end

    // Left shift never takes the exponent below 1; what remains is subnormal.
    max_sh = x_exp_reg - 5'd1;
    sh     = ({1'b0, lz} > max_sh) ? max_sh[3:0] : lz;

    if (sum[14]) begin
      norm_man = {sum[14:2], sum[1] | sum[0]};
      norm_exp = {1'b0, x_exp_reg} + 6'd1;
    end else begin
      norm_man = sum[13:0] << sh;
      norm_exp = {1'b0, x_exp_reg} - {2'b00, sh};
    end

    // norm_man: [13] hidden, [12:3] fraction, [2] guard, [1] round, [0] sticky
    inexact = |norm_man[2:0];
    rnd_up  = !rtz_reg && norm_man[2] && (norm_man[1] || norm_man[0] || norm_man[3]);
    rounded = {1'b0, norm_man[13:3]} + {11'd0, rnd_up};

    if (rounded[11]) begin
      fin_exp  = norm_exp + 6'd1;
      fin_frac = rounded[10:1];
    end else if (rounded[10]) begin
      fin_exp  = norm_exp;
      fin_frac = rounded[9:0];
    end else begin
      fin_exp  = 6'd0;
      fin_frac = rounded[9:0];
    end

    ovf = (fin_exp >= 6'd31);
    uf  = (fin_exp == 6'd0) && inexact;

    res_next = {x_sign_reg, fin_exp[4:0], fin_frac};
    sts_next = {3'b000, uf, inexact};
    if (spec_hit_reg) begin
      res_next = spec_res_reg;
      sts_next = {spec_nv_reg, 4'b0000};
    end else if (sum == 15'd0) begin
      // exact cancellation is +0; only like-signed zeros keep their sign
      res_next = {x_sign_reg & ~eff_sub_reg, 15'd0};
      sts_next = 5'b00000;
    end else if (ovf) begin
      res_next = rtz_reg ? {x_sign_reg, 15'h7BFF} : {x_sign_reg, 15'h7C00};
      sts_next = 5'b00101;
    end
  end

  // ------------------------------------------------------------------
  // Response registers: written only on the NORM->DONE step, so they
  // hold steady while the response is back-pressured.
  // ------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      result_o <= '0;
      status_o <= '0;
      tag_o    <= '0;
    end else if ((state_reg == NORM) && !flush_i) begin
      result_o <= res_next;
      status_o <= sts_next;
      tag_o    <= tag_req_reg;
    end
  end

endmodule

// File: tb/tb_fp16_addsub_unit.sv
// Self-checking bench for fp16_addsub_unit: directed cases, handshake,
// flush and reset behaviour, then randomized operations against an
// exact-arithmetic reference model.

module tb_fp16_addsub_unit;

  localparam int TW = 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0][15:0] operands;
  logic             op_mod;
  logic [2:0]       rnd_mode;
  logic [TW-1:0]    tag;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      result;
  logic [4:0]       status;
  logic [TW-1:0]    tag_o;
  logic             out_valid;
  logic             out_ready;
  logic             flush;
  logic             busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fp16_addsub_unit #(.TagWidth(TW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .operands_i  (operands),
    .op_mod_i    (op_mod),
    .rnd_mode_i  (rnd_mode),
    .tag_i       (tag),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .result_o    (result),
    .status_o    (status),
    .tag_o       (tag_o),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .flush_i     (flush),
    .busy_o      (busy)
  );

  task automatic check_value(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Signed value in units of 2^-24 (the smallest subnormal), exact for all finite FP16.
  function automatic longint fp_val(input logic [15:0] h);
    int     e;
    longint m, v;
    e = int'(h[14:10]);
    m = longint'(h[9:0]);
    if (e == 0) v = m;
    else        v = (m + 1024) << (e - 1);
    return h[15] ? -v : v;
  endfunction

  // Returns {status, result}. Adds exactly, then rounds the exact sum onto the FP16 grid.
  function automatic logic [20:0] ref_model(input logic [15:0] a, input logic [15:0] b_in,
                                            input logic sub, input logic rtz);
    logic [15:0] b;
    logic        a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, sign, nx;
    longint      s, n, q, rem, half;
    int          p, e, sh, field;
    b      = b_in;
    b[15]  = b_in[15] ^ sub;
    a_nan  = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
    b_nan  = (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
    a_snan = a_nan && !a[9];
    b_snan = b_nan && !b[9];
    a_inf  = (a[14:10] == 5'h1F) && (a[9:0] == 10'd0);
    b_inf  = (b[14:10] == 5'h1F) && (b[9:0] == 10'd0);
    if (a_nan || b_nan) return {a_snan || b_snan, 4'b0000, 16'h7E00};
    if (a_inf && b_inf) begin
      if (a[15] != b[15]) return {5'b10000, 16'h7E00};
      return {5'b00000, a};
    end
    if (a_inf) return {5'b00000, a};
    if (b_inf) return {5'b00000, b};
    s = fp_val(a) + fp_val(b);
    if (s == 0) begin
      sign = (a[14:0] == 15'd0) && (b[14:0] == 15'd0) && a[15] && b[15];
      return {5'b00000, sign, 15'd0};
    end
    sign = (s < 0);
    n    = sign ? -s : s;
    p    = 0;
    for (int i = 0; i < 48; i++) if (n[i]) p = i;
    rem = 0;
    if (p <= 10) begin
      e = 1;
      q = n;
    end else begin
      e    = p - 9;
      sh   = e - 1;
      q    = n >> sh;
      rem  = n - (q << sh);
      half = longint'(1) << (sh - 1);
      if (!rtz && (rem > half || (rem == half && q[0]))) q = q + 1;
    end
    nx = (rem != 0);
    if (q == 2048) begin
      q = 1024;
      e = e + 1;
    end
    if (e >= 31) return {5'b00101, sign, rtz ? 15'h7BFF : 15'h7C00};
    field = (q >= 1024) ? e : 0;
    return {3'b000, (field == 0) && nx, nx, sign, 5'(field), 10'(q & 1023)};
  endfunction

  // One full transaction with out_ready held high.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic m,
                       input logic [2:0] rnd, input logic [TW-1:0] tg);
    logic [20:0] want;
    int          n;
    int          busy_n;
    want = ref_model(a, b, m, rnd == 3'b001);
    check_value("in_ready_idle", {31'd0, in_ready}, 32'd1);
    operands[0] = a;
    operands[1] = b;
    op_mod      = m;
    rnd_mode    = rnd;
    tag         = tg;
    in_valid    = 1'b1;
    @(posedge clk); #1;
    in_valid    = 1'b0;
    operands[0] = 16'($urandom);
    operands[1] = 16'($urandom);
    op_mod      = ~m;
    tag         = ~tg;
    busy_n = busy ? 1 : 0;
    n = 0;
    while (!out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
      busy_n += busy ? 1 : 0;
    end
    check_value("latency", n, 2);
    check_value("result", {16'd0, result}, {16'd0, want[15:0]});
    check_value("status", {27'd0, status}, {27'd0, want[20:16]});
    check_value("tag", {{(32-TW){1'b0}}, tag_o}, {{(32-TW){1'b0}}, tg});
    $display("op a=%h b=%h sub=%0d rnd=%0d -> res=%h st=%b (model %h %b)",
             a, b, m, rnd, result, status, want[15:0], want[20:16]);
    @(posedge clk); #1;
    busy_n += busy ? 1 : 0;
    check_value("busy_cycles", busy_n, 3);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ra, rb;
    logic [20:0] want;
    int          n, mode, seen;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    operands  = '0;
    op_mod    = 1'b0;
    rnd_mode  = 3'd0;
    tag       = '0;
    out_ready = 1'b1;
    flush     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_value("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_value("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_value("rst_busy", {31'd0, busy}, 32'd0);
    check_value("rst_result", {16'd0, result}, 32'd0);
    check_value("rst_status", {27'd0, status}, 32'd0);
    check_value("rst_tag", {{(32-TW){1'b0}}, tag_o}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    do_op(16'h3C00, 16'h3C00, 1'b0, 3'd0, 1'b1);
    do_op(16'h4200, 16'h4000, 1'b1, 3'd0, 1'b0);
    do_op(16'h3C00, 16'h3C00, 1'b1, 3'd0, 1'b1);
    do_op(16'h3C00, 16'h0001, 1'b0, 3'd0, 1'b0);
    do_op(16'h7BFF, 16'h7BFF, 1'b0, 3'd0, 1'b1);
    do_op(16'h7BFF, 16'h7BFF, 1'b0, 3'd1, 1'b0);
    do_op(16'h7BFF, 16'h7BFF, 1'b0, 3'd7, 1'b1);
    do_op(16'h7C00, 16'h7C00, 1'b1, 3'd0, 1'b1);
    do_op(16'h7D00, 16'h3C00, 1'b0, 3'd0, 1'b0);
    do_op(16'h7E00, 16'h3C00, 1'b0, 3'd0, 1'b1);
    do_op(16'hFC00, 16'h4500, 1'b1, 3'd0, 1'b0);
    do_op(16'h0001, 16'h0001, 1'b0, 3'd0, 1'b0);
    do_op(16'h0400, 16'h0001, 1'b1, 3'd0, 1'b1);
    do_op(16'h8000, 16'h8000, 1'b0, 3'd0, 1'b0);
    do_op(16'h3C00, 16'h1001, 1'b0, 3'd1, 1'b1);

    // Reset in the middle of an operation clears outputs asynchronously
    operands[0] = 16'h4000;
    operands[1] = 16'h4000;
    op_mod      = 1'b0;
    rnd_mode    = 3'd0;
    tag         = 1'b1;
    in_valid    = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_value("midrst_result", {16'd0, result}, 32'd0);
    check_value("midrst_status", {27'd0, status}, 32'd0);
    check_value("midrst_tag", {{(32-TW){1'b0}}, tag_o}, 32'd0);
    check_value("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check_value("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check_value("midrst_busy", {31'd0, busy}, 32'd0);
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Backpressure: response held stable, new request ignored
    want        = ref_model(16'h4500, 16'h3800, 1'b1, 1'b0);
    out_ready   = 1'b0;
    operands[0] = 16'h4500;
    operands[1] = 16'h3800;
    op_mod      = 1'b1;
    rnd_mode    = 3'd0;
    tag         = 1'b1;
    in_valid    = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check_value("bp_latency", n, 2);
    operands[0] = 16'h3C00;
    operands[1] = 16'h3C00;
    op_mod      = 1'b0;
    tag         = 1'b0;
    in_valid    = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      check_value("bp_result", {16'd0, result}, {16'd0, want[15:0]});
      check_value("bp_status", {27'd0, status}, {27'd0, want[20:16]});
      check_value("bp_tag", {{(32-TW){1'b0}}, tag_o}, 32'd1);
      check_value("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check_value("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_value("bp_release_valid", {31'd0, out_valid}, 32'd0);
    check_value("bp_release_busy", {31'd0, busy}, 32'd0);

    // Flush together with a request in IDLE: nothing accepted
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    check_value("flush_idle_busy", {31'd0, busy}, 32'd0);

    // Flush in ALIGN: no response ever appears
    operands[0] = 16'h3C00;
    operands[1] = 16'h4000;
    in_valid    = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_value("align_busy", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check_value("flush_busy", {31'd0, busy}, 32'd0);
    check_value("flush_in_ready", {31'd0, in_ready}, 32'd1);
    seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    check_value("flush_no_resp", seen, 0);
    do_op(16'h3E00, 16'h3E00, 1'b0, 3'd0, 1'b1);

    // Randomized operations
    for (int k = 0; k < 300; k++) begin
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      mode = $urandom_range(0, 4);
      case (mode)
        1: rb[14:10] = ra[14:10];
        2: rb[14:10] = ra[14:10] + 5'd1;
        3: begin
          ra[14:10] = 5'd0;
          rb[14:10] = 5'($urandom_range(0, 1));
        end
        4: rb[14:10] = ra[14:10] - 5'd5;
        default: ;
      endcase
      do_op(ra, rb, 1'($urandom), 3'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
